// File: rtl/mgt_01_div_issue_queue.sv
// -----------------------------------------------------------------------------
// mgt_01_div_issue_queue
//
// Purpose:
//   Small in-order issue queue that sits between decode and an iterative
//   32-bit divider. Decoded divide/remainder ops are buffered in a circular
//   FIFO. The head is handed to the divider one op at a time. The result is
//   presented to writeback until it is accepted. The corner cases with a
//   defined architectural answer (divide by zero, signed overflow) never
//   reach the divider. They are answered directly from the head entry.
//
// Parameters:
//   DEPTH  number of queue entries (power of two, >= 2)
//   TAG_W  width of the destination-register tag
//
// Ports:
//   clk_i           clock, all state updates on the rising edge
//   rst_n_i         synchronous active-low reset
//   clk_en_i        clock enable; 0 freezes every register
//   valid_i         decode offers an op this cycle
//   ready_o         queue has a free entry (NOT full)
//   dividend_i      operand A of the offered op
//   divisor_i       operand B of the offered op
//   ops_i           0 = DIV, 1 = DIVU, 2 = REM, 3 = REMU
//   tag_i           destination register of the offered op
//   flush_i         pipeline flush: empties queue, drops result, back to IDLE
//   dividend_o      operand A to the divider (head entry while busy, else 0)
//   divisor_o       operand B to the divider (head entry while busy, else 0)
//   ops_o           op code to the divider (head entry while busy, else DIV)
//   is_division_o   divider start/hold request
//   div_done_i      divider result valid (one-cycle pulse)
//   div_result_i    divider result
//   result_valid_o  a result is waiting for writeback
//   result_o        result value
//   result_tag_o    destination register of the result
//   wb_ready_i      writeback accepts the result this cycle
// -----------------------------------------------------------------------------
module mgt_01_div_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clk_en_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      dividend_i,
    input  logic [31:0]      divisor_i,
    input  logic [1:0]       ops_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic [31:0]      dividend_o,
    output logic [31:0]      divisor_o,
    output logic [1:0]       ops_o,
    output logic             is_division_o,
    input  logic             div_done_i,
    input  logic [31:0]      div_result_i,
    output logic             result_valid_o,
    output logic [31:0]      result_o,
    output logic [TAG_W-1:0] result_tag_o,
    input  logic             wb_ready_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OP_DIV  = 2'd0;

    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // Storage and state
    // -------------------------------------------------------------------------
    logic [31:0]      dividendMem [DEPTH];
    logic [31:0]      divisorMem  [DEPTH];
    logic [1:0]       opsMem      [DEPTH];
    logic [TAG_W-1:0] tagMem      [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_e           state_q, state_d;
    logic [31:0]      result_q, result_d;
    logic [TAG_W-1:0] resultTag_q, resultTag_d;

    logic             isEmpty;
    logic             isFull;
    logic             pushEn;
    logic             popEn;

    logic [31:0]      headDividend;
    logic [31:0]      headDivisor;
    logic [1:0]       headOps;
    logic [TAG_W-1:0] headTag;

    logic             divByZero;
    logic             signedOverflow;
    logic             fastPath;
    logic [31:0]      fastResult;

    // -------------------------------------------------------------------------
    // Occupancy. The count disambiguates full from empty when the pointers
    // are equal. A flush wins over a simultaneous push, so the push is
    // qualified with it here.
    // -------------------------------------------------------------------------
    always_comb begin
        isEmpty = (count_q == '0);
        isFull  = (count_q == CNT_W'(DEPTH));
        ready_o = !isFull;
        pushEn  = valid_i && !isFull && !flush_i;
    end

    // -------------------------------------------------------------------------
    // Head entry and fast-path classification. DIV and REM are the signed
    // ops (bit 0 clear). The REM variants have bit 1 set.
    // -------------------------------------------------------------------------
    always_comb begin
        headDividend   = dividendMem[rdPtr_q];
        headDivisor    = divisorMem[rdPtr_q];
        headOps        = opsMem[rdPtr_q];
        headTag        = tagMem[rdPtr_q];

        divByZero      = (headDivisor == '0);
        signedOverflow = !headOps[0] && (headDividend == INT_MIN) &&
                         (headDivisor == ALL_ONES);
        fastPath       = divByZero || signedOverflow;

        fastResult     = '0;
        if (divByZero) begin
            fastResult = headOps[1] ? headDividend : ALL_ONES;
        end else if (signedOverflow) begin
            fastResult = headOps[1] ? 32'd0 : INT_MIN;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state. The head stays in the queue while the divider works on
    // it. It is popped when its result is captured, on either path. A flush
    // overrides everything, including a divider completion in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        resultTag_d = resultTag_q;
        popEn       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!isEmpty) begin
                    if (fastPath) begin
                        state_d     = RESP;
                        result_d    = fastResult;
                        resultTag_d = headTag;
                        popEn       = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (div_done_i) begin
                    state_d     = RESP;
                    result_d    = div_result_i;
                    resultTag_d = headTag;
                    popEn       = 1'b1;
                end
            end
            RESP: begin
                if (wb_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = IDLE;
            popEn   = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Pointer and count next state. DEPTH is a power of two, so the pointers
    // wrap naturally at their width.
    // -------------------------------------------------------------------------
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;

        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            if (pushEn && !popEn) begin
                count_d = count_q + CNT_W'(1);
            end else if (!pushEn && popEn) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Reset wins over the clock enable. With the enable low
    // every register holds, so no handshake can complete.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            result_q    <= '0;
            resultTag_q <= '0;
        end else if (clk_en_i) begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            result_q    <= result_d;
            resultTag_q <= resultTag_d;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage. It needs no reset because the pointers and the count
    // decide what is valid.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_n_i && clk_en_i && pushEn) begin
            dividendMem[wrPtr_q] <= dividend_i;
            divisorMem[wrPtr_q]  <= divisor_i;
            opsMem[wrPtr_q]      <= ops_i;
            tagMem[wrPtr_q]      <= tag_i;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The divider operands are only driven while a request is
    // outstanding. This keeps them at their reset value everywhere else.
    // Everything here comes from registers, so a frozen clock enable also
    // freezes the outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        is_division_o  = (state_q == BUSY);
        dividend_o     = is_division_o ? headDividend : 32'd0;
        divisor_o      = is_division_o ? headDivisor  : 32'd0;
        ops_o          = is_division_o ? headOps      : OP_DIV;
        result_valid_o = (state_q == RESP);
        result_o       = result_q;
        result_tag_o   = resultTag_q;
    end

endmodule

// File: tb/tb_mgt_01_div_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_mgt_01_div_issue_queue
//
// Self-checking bench for the divide issue queue. It runs these phases in
// order:
//   - directed vector table (normal, divide-by-zero and overflow ops)
//   - hand-written multi-cycle sequences: fill and wrap, writeback stall,
//     flush, clock enable and reset while busy
//   - randomized traffic checked against an in-order result queue
// The bench also acts as the divider, computing quotients with plain
// SystemVerilog arithmetic.
// -----------------------------------------------------------------------------
module tb_mgt_01_div_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             clk_en_i;
    logic             valid_i;
    logic             ready_o;
    logic [31:0]      dividend_i;
    logic [31:0]      divisor_i;
    logic [1:0]       ops_i;
    logic [TAG_W-1:0] tag_i;
    logic             flush_i;
    logic [31:0]      dividend_o;
    logic [31:0]      divisor_o;
    logic [1:0]       ops_o;
    logic             is_division_o;
    logic             div_done_i;
    logic [31:0]      div_result_i;
    logic             result_valid_o;
    logic [31:0]      result_o;
    logic [TAG_W-1:0] result_tag_o;
    logic             wb_ready_i;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        logic [1:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      expRes;
        bit               expFast;
    } vec_t;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    vec_t vecs[10];
    exp_t modelQ[$];

    mgt_01_div_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .clk_en_i       (clk_en_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .ops_i          (ops_i),
        .tag_i          (tag_i),
        .flush_i        (flush_i),
        .dividend_o     (dividend_o),
        .divisor_o      (divisor_o),
        .ops_o          (ops_o),
        .is_division_o  (is_division_o),
        .div_done_i     (div_done_i),
        .div_result_i   (div_result_i),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .result_tag_o   (result_tag_o),
        .wb_ready_i     (wb_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Watchdog so the run always ends even if a wait logic bug slips through
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Architectural divide result computed straight from the op rules
    function automatic logic [31:0] refDivide(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0:    if (b == 0) return 32'hFFFF_FFFF;
                     else if (ovf) return 32'h8000_0000;
                     else return 32'($signed(a) / $signed(b));
            2'd1:    if (b == 0) return 32'hFFFF_FFFF;
                     else return a / b;
            2'd2:    if (b == 0) return a;
                     else if (ovf) return 32'd0;
                     else return 32'($signed(a) % $signed(b));
            default: if (b == 0) return a;
                     else return a % b;
        endcase
    endfunction

    // Outputs are sampled 1 time unit after the active edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        nChecks++;
        nFail++;
        $display("[TB] FAIL %s: bound expired, got timeout, expected event", name);
    endtask

    task automatic idleInputs();
        valid_i      = 1'b0;
        dividend_i   = '0;
        divisor_i    = '0;
        ops_i        = '0;
        tag_i        = '0;
        flush_i      = 1'b0;
        div_done_i   = 1'b0;
        div_result_i = '0;
        wb_ready_i   = 1'b0;
        clk_en_i     = 1'b1;
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, " ready"},     32'(ready_o), 32'd1);
        checkOutput({name, " isDiv"},     32'(is_division_o), 32'd0);
        checkOutput({name, " resValid"},  32'(result_valid_o), 32'd0);
        checkOutput({name, " result"},    result_o, 32'd0);
        checkOutput({name, " resTag"},    32'(result_tag_o), 32'd0);
        checkOutput({name, " dividendO"}, dividend_o, 32'd0);
        checkOutput({name, " divisorO"},  divisor_o, 32'd0);
        checkOutput({name, " opsO"},      32'(ops_o), 32'd0);
    endtask

    // Push one op, waiting a bounded time for space in the queue
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [TAG_W-1:0] tag);
        int waitCnt = 0;
        while (!ready_o && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        if (!ready_o) failNow("push wait ready");
        valid_i    = 1'b1;
        ops_i      = op;
        dividend_i = a;
        divisor_i  = b;
        tag_i      = tag;
        tick();
        valid_i    = 1'b0;
    endtask

    task automatic waitIssue(input string name);
        int waitCnt = 0;
        while (!is_division_o && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        if (!is_division_o) failNow(name);
    endtask

    // Wait for the head result, playing the divider when asked. The divider
    // answers on the second busy cycle. Fast-path ops must never ask.
    task automatic expectResult(input string name, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [TAG_W-1:0] tag,
                                input logic [31:0] expRes, input bit expFast);
        bit sawDiv = 0;
        bit got    = 0;
        int busyCycles = 0;
        int latency = 0;
        for (int c = 0; c < 40; c++) begin
            if (result_valid_o) begin
                got = 1;
                latency = c;
                break;
            end
            if (is_division_o) begin
                sawDiv = 1;
                busyCycles++;
                if (busyCycles == 2) begin
                    checkOutput({name, " dividendO"}, dividend_o, a);
                    checkOutput({name, " divisorO"}, divisor_o, b);
                    checkOutput({name, " opsO"}, 32'(ops_o), 32'(op));
                    div_done_i   = 1'b1;
                    div_result_i = refDivide(ops_o, dividend_o, divisor_o);
                end
            end
            tick();
            div_done_i = 1'b0;
        end
        if (!got) begin
            failNow({name, " result wait"});
        end else begin
            checkOutput({name, " result"}, result_o, expRes);
            checkOutput({name, " tag"}, 32'(result_tag_o), 32'(tag));
            checkOutput({name, " usedDivider"}, 32'(sawDiv), 32'(!expFast));
            if (expFast) checkOutput({name, " fastLatency<=1"}, 32'(latency <= 1), 32'd1);
        end
    endtask

    task automatic ackResult(input string name);
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        checkOutput({name, " retired"}, 32'(result_valid_o), 32'd0);
    endtask

    task automatic randomOp(output logic [1:0] op, output logic [31:0] a,
                            output logic [31:0] b);
        op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0:       a = 32'h8000_0000;
            1:       a = 32'($urandom_range(0, 1000));
            default: a = $urandom;
        endcase
        case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 20));
            default: b = $urandom;
        endcase
    endtask

    initial begin
        logic [1:0]       rOp;
        logic [31:0]      rA, rB;
        logic [TAG_W-1:0] rTag;
        exp_t             e;

        // Directed vectors: {op, dividend, divisor, tag, expected, fast}
        vecs[0] = '{2'd0, 32'd100,         32'd5,           5'd3,  32'd20,          1'b0};
        vecs[1] = '{2'd0, 32'hFFFF_FFB0,   32'd0,           5'd4,  32'hFFFF_FFFF,   1'b1};
        vecs[2] = '{2'd2, 32'hFFFF_FE6E,   32'd0,           5'd5,  32'hFFFF_FE6E,   1'b1};
        vecs[3] = '{2'd0, 32'h8000_0000,   32'hFFFF_FFFF,   5'd6,  32'h8000_0000,   1'b1};
        vecs[4] = '{2'd2, 32'h8000_0000,   32'hFFFF_FFFF,   5'd7,  32'd0,           1'b1};
        vecs[5] = '{2'd1, 32'h8000_0000,   32'hFFFF_FFFF,   5'd8,  32'd0,           1'b0};
        vecs[6] = '{2'd3, 32'd7,           32'd0,           5'd9,  32'd7,           1'b1};
        vecs[7] = '{2'd1, 32'd0,           32'd0,           5'd10, 32'hFFFF_FFFF,   1'b1};
        vecs[8] = '{2'd2, 32'hFFFF_FFF9,   32'd2,           5'd11, 32'hFFFF_FFFF,   1'b0};
        vecs[9] = '{2'd0, 32'hFFFF_FFF9,   32'd2,           5'd31, 32'hFFFF_FFFD,   1'b0};

        idleInputs();
        rst_n_i = 1'b0;
        tick();
        tick();
        checkResetOutputs("reset");
        rst_n_i = 1'b1;
        tick();

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            expectResult($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                         vecs[i].tag, vecs[i].expRes, vecs[i].expFast);
            ackResult($sformatf("vec%0d", i));
        end

        $display("[TB] fill to full and wrap");
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        applyStimulus(2'd0, 32'd10,  32'd2, 5'd10);
        applyStimulus(2'd1, 32'd21,  32'd3, 5'd11);
        applyStimulus(2'd2, 32'd17,  32'd5, 5'd12);
        applyStimulus(2'd3, 32'd100, 32'd7, 5'd13);
        checkOutput("full ready", 32'(ready_o), 32'd0);
        valid_i = 1'b1; ops_i = 2'd1; dividend_i = 32'd99; divisor_i = 32'd1; tag_i = 5'd30;
        tick();
        tick();
        valid_i = 1'b0;
        checkOutput("full reject ready", 32'(ready_o), 32'd0);
        expectResult("wrap0", 2'd0, 32'd10, 32'd2, 5'd10, 32'd5, 1'b0);
        checkOutput("wrap space ready", 32'(ready_o), 32'd1);
        ackResult("wrap0");
        applyStimulus(2'd0, 32'hFFFF_FF9C, 32'd4, 5'd14);
        expectResult("wrap1", 2'd1, 32'd21,  32'd3, 5'd11, 32'd7, 1'b0);
        ackResult("wrap1");
        expectResult("wrap2", 2'd2, 32'd17,  32'd5, 5'd12, 32'd2, 1'b0);
        ackResult("wrap2");
        expectResult("wrap3", 2'd3, 32'd100, 32'd7, 5'd13, 32'd2, 1'b0);
        ackResult("wrap3");
        expectResult("wrap4", 2'd0, 32'hFFFF_FF9C, 32'd4, 5'd14, 32'hFFFF_FFE7, 1'b0);
        ackResult("wrap4");

        $display("[TB] writeback stall");
        applyStimulus(2'd0, 32'd1000, 32'd10, 5'd7);
        applyStimulus(2'd1, 32'd50,   32'd7,  5'd8);
        expectResult("stall0", 2'd0, 32'd1000, 32'd10, 5'd7, 32'd100, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall valid", 32'(result_valid_o), 32'd1);
            checkOutput("stall result", result_o, 32'd100);
            checkOutput("stall noIssue", 32'(is_division_o), 32'd0);
        end
        ackResult("stall0");
        expectResult("stall1", 2'd1, 32'd50, 32'd7, 5'd8, 32'd7, 1'b0);
        ackResult("stall1");

        $display("[TB] flush while busy");
        applyStimulus(2'd0, 32'd9, 32'd3, 5'd1);
        waitIssue("flush issue wait");
        flush_i = 1'b1;
        valid_i = 1'b1; ops_i = 2'd1; dividend_i = 32'd8; divisor_i = 32'd2; tag_i = 5'd2;
        div_done_i = 1'b1; div_result_i = 32'd3;
        tick();
        flush_i = 1'b0; valid_i = 1'b0; div_done_i = 1'b0;
        checkOutput("flush isDiv", 32'(is_division_o), 32'd0);
        checkOutput("flush resValid", 32'(result_valid_o), 32'd0);
        checkOutput("flush ready", 32'(ready_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            div_done_i = (i == 1);
            div_result_i = 32'd3;
            tick();
            div_done_i = 1'b0;
            checkOutput("flush late isDiv", 32'(is_division_o), 32'd0);
            checkOutput("flush late resValid", 32'(result_valid_o), 32'd0);
        end

        $display("[TB] clock enable");
        clk_en_i = 1'b0;
        valid_i = 1'b1; ops_i = 2'd1; dividend_i = 32'd8; divisor_i = 32'd2; tag_i = 5'd2;
        tick();
        valid_i = 1'b0;
        clk_en_i = 1'b1;
        tick();
        tick();
        checkOutput("cken push blocked", 32'(is_division_o), 32'd0);
        applyStimulus(2'd1, 32'd5, 32'd0, 5'd20);
        expectResult("cken fast", 2'd1, 32'd5, 32'd0, 5'd20, 32'hFFFF_FFFF, 1'b1);
        clk_en_i = 1'b0;
        wb_ready_i = 1'b1;
        tick();
        tick();
        checkOutput("cken hold valid", 32'(result_valid_o), 32'd1);
        checkOutput("cken hold tag", 32'(result_tag_o), 32'd20);
        clk_en_i = 1'b1;
        wb_ready_i = 1'b0;
        ackResult("cken fast");

        $display("[TB] reset while busy");
        applyStimulus(2'd0, 32'd77, 32'd7, 5'd21);
        waitIssue("reset issue wait");
        rst_n_i = 1'b0;
        tick();
        checkResetOutputs("midBusyReset");
        rst_n_i = 1'b1;
        div_done_i = 1'b1;
        div_result_i = 32'd11;
        tick();
        div_done_i = 1'b0;
        tick();
        checkOutput("reset late resValid", 32'(result_valid_o), 32'd0);
        checkOutput("reset late isDiv", 32'(is_division_o), 32'd0);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 600; cyc++) begin
            clk_en_i   = ($urandom_range(0, 9) != 0);
            wb_ready_i = ($urandom_range(0, 2) != 0);
            div_done_i = 1'b0;
            if (is_division_o && $urandom_range(0, 2) == 0) begin
                div_done_i   = 1'b1;
                div_result_i = refDivide(ops_o, dividend_o, divisor_o);
            end
            valid_i = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                randomOp(rOp, rA, rB);
                rTag = TAG_W'($urandom);
                valid_i = 1'b1; ops_i = rOp; dividend_i = rA; divisor_i = rB; tag_i = rTag;
                if (ready_o && clk_en_i) begin
                    e.res = refDivide(rOp, rA, rB);
                    e.tag = rTag;
                    modelQ.push_back(e);
                end
            end
            if (result_valid_o && wb_ready_i && clk_en_i) begin
                if (modelQ.size() == 0) begin
                    checkOutput("rand unexpected result", 32'(result_valid_o), 32'd0);
                end else begin
                    e = modelQ.pop_front();
                    checkOutput("rand result", result_o, e.res);
                    checkOutput("rand tag", 32'(result_tag_o), 32'(e.tag));
                end
            end
            tick();
        end

        valid_i = 1'b0;
        clk_en_i = 1'b1;
        wb_ready_i = 1'b1;
        for (int cyc = 0; cyc < 300 && modelQ.size() > 0; cyc++) begin
            div_done_i = 1'b0;
            if (is_division_o) begin
                div_done_i   = 1'b1;
                div_result_i = refDivide(ops_o, dividend_o, divisor_o);
            end
            if (result_valid_o) begin
                e = modelQ.pop_front();
                checkOutput("drain result", result_o, e.res);
                checkOutput("drain tag", 32'(result_tag_o), 32'(e.tag));
            end
            tick();
        end
        div_done_i = 1'b0;
        wb_ready_i = 1'b0;
        if (modelQ.size() != 0) failNow("drain results");
        tick();
        checkOutput("drain empty ready", 32'(ready_o), 32'd1);
        checkOutput("drain empty isDiv", 32'(is_division_o), 32'd0);
        checkOutput("drain empty resValid", 32'(result_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
